lfsr_checker: RTL and testbench
===============================

# lfsr_checker

Serial pseudo-random sequence checker placed directly downstream of the `lfsr` generator. It consumes the generator's serial output bit, self-synchronises to the sequence, and declares lock after a run of correct predictions. Once locked, it flags and counts every mismatching bit. It provides the pass/fail observation point for the LFSR test path, so benches and on-chip monitors need not re-derive the sequence.

## Interface
Parameters:
- `WIDTH`, 8: LFSR length in bits. Range 3..32.
- `TAPS`, 8'b1011_1000: feedback tap mask, bit i ↔ register bit i (x^8+x^6+x^5+x^4+1 for the default). Must match the generator.
- `LOCK_COUNT`, 16: consecutive correct predictions required to declare lock. Minimum 1.
- `LOSS_LIMIT`, 4: consecutive mismatches while locked that drop lock. Minimum 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  qualifies `in_bit`. The block advances only when this is high.
- `in_bit`  in  1  serial sequence bit (the generator's `output_value[1]`).
- `clear_count`  in  1  synchronous clear of `err_count`.
- `locked`  out  1  high while in LOCKED.
- `err_pulse`  out  1  one-cycle pulse per mismatched bit while LOCKED.
- `lost`  out  1  one-cycle pulse when LOCKED is exited due to errors.
- `err_count`  out  16  saturating mismatch counter. Counts only while LOCKED.

## Operation
- The local register `sr[WIDTH:1]` holds the last WIDTH bits. A new bit enters at `sr[1]` and the register shifts toward `sr[WIDTH]`.
- Prediction: `p = ^(sr & TAPS)`.
- **HUNT** (the reset state):
  - Each valid bit shifts the received `in_bit` into `sr`, and `fill` increments.
  - When `fill` reaches WIDTH:
    - If `sr` is all zeros, `fill` clears and the block stays in HUNT. This prevents false lock on a dead line.
    - Otherwise the block goes to VERIFY with `run`=0.
- **VERIFY**:
  - Each valid bit compares `in_bit` against `p`.
  - `sr` shifts in `p`, never `in_bit`, so errors do not propagate.
  - On a match, `run` increments. When `run` reaches LOCK_COUNT, the block goes to LOCKED.
  - On a mismatch, the block goes to HUNT with `fill`=0.
- **LOCKED**:
  - `sr` free-runs on `p` for each valid bit.
  - On a mismatch: `err_pulse` fires, `err_count` increments (saturating at 16'hFFFF), and `miss` increments.
  - On a match, `miss` clears.
  - When `miss` reaches LOSS_LIMIT: `lost` pulses, the block goes to HUNT, and `fill` clears. This transition exists only with the relock macro; see Configuration.
- When `in_valid` is low, all state, counters and `sr` hold. Pulses are low.
- `clear_count` together with a mismatch in the same cycle: the clear wins, and `err_count` becomes 0.
- `err_count` is not cleared by loss of lock. Only `reset` and `clear_count` clear it.

## Timing
- All outputs are registered.
- Reset values:
  - Outputs: `locked`=0, `err_pulse`=0, `lost`=0, `err_count`=0.
  - Internal: state HUNT, `sr`=0, `fill`=`run`=`miss`=0.
- `err_pulse` and the `err_count` update are visible in the cycle after the valid cycle carrying the bad bit.
- `locked` rises in the cycle after the valid cycle of the LOCK_COUNT-th correct prediction.
- `locked` falls in the same cycle that `lost` pulses, which is one cycle after the LOSS_LIMIT-th consecutive miss.
- Minimum lock latency is WIDTH + LOCK_COUNT valid bits. The default is 24.
- Reset asserted mid-operation immediately (asynchronously) forces all reset values. Lock must be reacquired from HUNT.
- The block accepts one bit per cycle with no back-pressure.

## Configuration
- Macro: `LFSR_CHECKER_RELOCK_EN`.
- **Defined**: LOSS_LIMIT consecutive mismatches in LOCKED cause the `lost` pulse and a return to HUNT. The checker then reacquires automatically.
- **Undefined**:
  - LOCKED is terminal until `reset`.
  - `lost` is tied to 0.
  - Mismatches still pulse `err_pulse` and count.
  - The LOSS_LIMIT logic is not built.

## Test plan
- **Reset**: drive `reset`=0 mid-stream → all outputs 0 immediately. After release, `locked` stays 0 for at least 24 valid bits.
- **Clean lock**: seed 8'hA5, feed the correct default-tap sequence continuously → `locked`=1 after exactly the 24th valid bit + 1 cycle. `err_count`=0 and no `err_pulse` over the following 1000 bits.
- **Single error**: while locked, flip 1 bit → exactly one `err_pulse`, `err_count`=1, `locked` stays 1. Hold `in_valid` low for 5 cycles mid-stream → no state change.
- **Loss and relock** (macro defined): flip 4 consecutive bits → `err_count`=4, `lost` pulses once, `locked`=0. Resume the clean stream → relock after 24 valid bits. With the macro undefined, the same stimulus gives `err_count`=4 and `locked` stays 1.
- **All-zero line**: feed 200 zero bits → `locked` never asserts and `err_count`=0.
- **Counter edges**:
  - `clear_count` coincident with a mismatch → `err_count`=0 next cycle.
  - Inject 65540 errors → `err_count` holds at 16'hFFFF.

Source files
------------

// File: rtl/lfsr_checker.sv
// Self-synchronising serial LFSR sequence checker: HUNT -> VERIFY -> LOCKED.
// Define LFSR_CHECKER_RELOCK_EN to drop lock after LOSS_LIMIT consecutive misses and reacquire.
module lfsr_checker #(
  parameter int unsigned       WIDTH      = 8,
  parameter logic [WIDTH-1:0]  TAPS       = 8'b1011_1000,
  parameter int unsigned       LOCK_COUNT = 16,
  parameter int unsigned       LOSS_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_bit,
  input  logic        clear_count,
  output logic        locked,
  output logic        err_pulse,
  output logic        lost,
  output logic [15:0] err_count
);

  localparam int unsigned FILL_W = $clog2(WIDTH + 1);
  localparam int unsigned RUN_W  = $clog2(LOCK_COUNT + 1);

  if (WIDTH < 3 || WIDTH > 32 || LOCK_COUNT < 1 || LOSS_LIMIT < 1) begin : g_bad_params
    $error("lfsr_checker: parameter out of range");
  end

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t              state_reg, state_next;
  logic [WIDTH-1:0]    sr_reg, sr_next;
  logic [FILL_W-1:0]   fill_reg, fill_next;
  logic [RUN_W-1:0]    run_reg, run_next;
  logic                locked_reg, locked_next;
  logic                err_pulse_reg, err_pulse_next;
  logic [15:0]         err_count_reg, err_count_next;
  logic                bit_err;
  logic                pred;
  logic [WIDTH-1:0]    hunt_sr;
  logic [WIDTH-1:0]    pred_sr;

  // sr_reg[0] is the most recently received bit (sr[1]); TAPS bit i lines up with sr_reg[i].
  assign pred    = ^(sr_reg & TAPS);
  assign hunt_sr = {sr_reg[WIDTH-2:0], in_bit};
  assign pred_sr = {sr_reg[WIDTH-2:0], pred};

`ifdef LFSR_CHECKER_RELOCK_EN
  localparam int unsigned MISS_W = $clog2(LOSS_LIMIT + 1);
  logic [MISS_W-1:0] miss_reg, miss_next;
  logic              loss;
  logic              lost_reg, lost_next;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= HUNT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sr_next    = sr_reg;
    fill_next  = fill_reg;
    run_next   = run_reg;
    bit_err    = 1'b0;
`ifdef LFSR_CHECKER_RELOCK_EN
    miss_next  = miss_reg;
    loss       = 1'b0;
`endif
    if (in_valid) begin
      case (state_reg)
        HUNT: begin
          sr_next = hunt_sr;
          if (fill_reg == FILL_W'(WIDTH - 1)) begin
            // An all-zero window is a dead line, not a sequence: keep hunting.
            fill_next = '0;
            if (hunt_sr != '0) begin
              state_next = VERIFY;
              run_next   = '0;
            end
          end else begin
            fill_next = fill_reg + FILL_W'(1);
          end
        end
        VERIFY: begin
          sr_next = pred_sr;
          if (in_bit == pred) begin
            run_next = run_reg + RUN_W'(1);
            if (run_reg == RUN_W'(LOCK_COUNT - 1)) begin
              state_next = LOCKED;
            end
          end else begin
            state_next = HUNT;
            fill_next  = '0;
          end
        end
        LOCKED: begin
          sr_next = pred_sr;
          bit_err = (in_bit != pred);
`ifdef LFSR_CHECKER_RELOCK_EN
          miss_next = '0;
          if (in_bit != pred) begin
            if (miss_reg == MISS_W'(LOSS_LIMIT - 1)) begin
              loss       = 1'b1;
              state_next = HUNT;
              fill_next  = '0;
            end else begin
              miss_next = miss_reg + MISS_W'(1);
            end
          end
`endif
        end
        default: begin
          state_next = HUNT;
          fill_next  = '0;
        end
      endcase
    end
  end

  always_comb begin
    locked_next    = (state_next == LOCKED);
    err_pulse_next = bit_err;
    err_count_next = err_count_reg;
    // A clear in the same cycle as a mismatch takes priority.
    if (clear_count) begin
      err_count_next = '0;
    end else if (bit_err && err_count_reg != 16'hFFFF) begin
      err_count_next = err_count_reg + 16'd1;
    end
`ifdef LFSR_CHECKER_RELOCK_EN
    lost_next = loss;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_reg        <= '0;
      fill_reg      <= '0;
      run_reg       <= '0;
      locked_reg    <= 1'b0;
      err_pulse_reg <= 1'b0;
      err_count_reg <= '0;
    end else begin
      sr_reg        <= sr_next;
      fill_reg      <= fill_next;
      run_reg       <= run_next;
      locked_reg    <= locked_next;
      err_pulse_reg <= err_pulse_next;
      err_count_reg <= err_count_next;
    end
  end

`ifdef LFSR_CHECKER_RELOCK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      miss_reg <= '0;
      lost_reg <= 1'b0;
    end else begin
      miss_reg <= miss_next;
      lost_reg <= lost_next;
    end
  end

  assign lost = lost_reg;
`else
  assign lost = 1'b0;
`endif

  assign locked    = locked_reg;
  assign err_pulse = err_pulse_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: a recurrence-based sequence source plus
// scenario-level expectations (lock latency, error pulses, counter saturation).
`timescale 1ns/1ps
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_bit;
  logic        clear_count;
  logic        locked, err_pulse, lost;
  logic [15:0] err_count;
  logic        s_locked, s_err_pulse, s_lost;
  logic [15:0] s_err_count;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  taps     = 8'b1011_1000;
  logic [7:0]  seed;
  logic        gen_q[$];
  logic [15:0] exp_count;
  int          run_flips;
  logic        f;

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk         (clk),
    .reset       (rst_n),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .clear_count (clear_count),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .lost        (lost),
    .err_count   (err_count)
  );

  // Second copy tolerates long error bursts so the counter can be driven to saturation.
  lfsr_checker #(.LOSS_LIMIT(70000)) dut_sat (
    .clk         (clk),
    .reset       (rst_n),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .clear_count (clear_count),
    .locked      (s_locked),
    .err_pulse   (s_err_pulse),
    .lost        (s_lost),
    .err_count   (s_err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_stream(input logic [7:0] s);
    seed = s;
    gen_q.delete();
  endtask

  // First 8 bits are the seed; afterwards b[n] = XOR of b[n-1-i] over set tap bits i.
  task automatic gen_next(output logic b);
    logic r;
    int   n;
    n = gen_q.size();
    if (n < 8) begin
      r = seed[7-n];
    end else begin
      r = 1'b0;
      for (int i = 0; i < 8; i++) if (taps[i]) r = r ^ gen_q[n-1-i];
    end
    gen_q.push_back(r);
    if (gen_q.size() > 8) void'(gen_q.pop_front());
    b = r;
  endtask

  task automatic drive(input logic v, input logic b, input logic c);
    in_valid    = v;
    in_bit      = b;
    clear_count = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic flip, input logic c);
    logic b;
    gen_next(b);
    drive(1'b1, b ^ flip, c);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; clear_count = 1'b0;
    exp_count = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_locked", locked, 0);
    chk("reset_err_pulse", err_pulse, 0);
    chk("reset_lost", lost, 0);
    chk("reset_err_count", err_count, 0);
    rst_n = 1'b1;

    // Clean lock from seed A5: locked visible right after the 24th valid bit.
    new_stream(8'hA5);
    for (int i = 1; i <= 24; i++) begin
      send(1'b0, 1'b0);
      chk("lock_latency", locked, (i == 24));
      chk("hunt_no_pulse", err_pulse, 0);
    end

    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        drive(1'b0, 1'($urandom), 1'b0);
        chk("gap_locked", locked, 1);
      end
      send(1'b0, 1'b0);
      chk("clean_err_pulse", err_pulse, 0);
      chk("clean_locked", locked, 1);
    end
    chk("clean_err_count", err_count, 0);

    // Single flipped bit.
    send(1'b1, 1'b0);
    exp_count = 16'd1;
    chk("single_pulse", err_pulse, 1);
    chk("single_count", err_count, 32'(exp_count));
    chk("single_locked", locked, 1);
    send(1'b0, 1'b0);
    chk("single_pulse_end", err_pulse, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'($urandom), 1'b0);
      chk("idle_pulse", err_pulse, 0);
      chk("idle_count", err_count, 32'(exp_count));
      chk("idle_locked", locked, 1);
    end
    for (int i = 0; i < 50; i++) begin
      send(1'b0, 1'b0);
      chk("post_idle_pulse", err_pulse, 0);
    end

    // Random sparse errors, never LOSS_LIMIT in a row.
    run_flips = 0;
    for (int i = 0; i < 300; i++) begin
      f = (run_flips < 3) && ($urandom_range(0, 9) == 0);
      run_flips = f ? run_flips + 1 : 0;
      if ($urandom_range(0, 9) == 0) drive(1'b0, 1'($urandom), 1'b0);
      send(f, 1'b0);
      if (f) exp_count = exp_count + 16'd1;
      chk("rand_pulse", err_pulse, f);
      chk("rand_count", err_count, 32'(exp_count));
      chk("rand_locked", locked, 1);
    end
    send(1'b0, 1'b0);
    chk("rand_tail_pulse", err_pulse, 0);

    // Four consecutive errors.
    for (int k = 1; k <= 4; k++) begin
      send(1'b1, 1'b0);
      exp_count = exp_count + 16'd1;
      chk("loss_pulse", err_pulse, 1);
      chk("loss_count", err_count, 32'(exp_count));
`ifdef LFSR_CHECKER_RELOCK_EN
      chk("loss_lost", lost, (k == 4));
      chk("loss_locked", locked, (k != 4));
`else
      chk("loss_lost", lost, 0);
      chk("loss_locked", locked, 1);
`endif
    end
    for (int i = 1; i <= 24; i++) begin
      send(1'b0, 1'b0);
      chk("lost_one_shot", lost, 0);
      chk("resume_pulse", err_pulse, 0);
`ifdef LFSR_CHECKER_RELOCK_EN
      chk("relock_latency", locked, (i == 24));
`else
      chk("stay_locked", locked, 1);
`endif
    end
    chk("count_survives_loss", err_count, 32'(exp_count));

    // Clear coincident with a mismatch: the clear wins.
    send(1'b1, 1'b1);
    exp_count = '0;
    chk("clr_count", err_count, 32'(exp_count));
    chk("clr_pulse", err_pulse, 1);
    send(1'b1, 1'b0);
    exp_count = 16'd1;
    chk("after_clr_count", err_count, 32'(exp_count));
    send(1'b0, 1'b0);

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    chk("async_locked", locked, 0);
    chk("async_err_count", err_count, 0);
    chk("async_err_pulse", err_pulse, 0);
    chk("async_lost", lost, 0);
    #2 rst_n = 1'b1;
    new_stream(8'($urandom_range(1, 255)));
    for (int i = 1; i <= 24; i++) begin
      send(1'b0, 1'b0);
      chk("reacquire_latency", locked, (i == 24));
    end

    // Dead line: 200 zeros never lock.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      chk("zero_locked", locked, 0);
      chk("zero_pulse", err_pulse, 0);
    end
    chk("zero_count", err_count, 0);
    new_stream(8'($urandom_range(1, 255)));
    for (int i = 1; i <= 24; i++) begin
      send(1'b0, 1'b0);
      chk("lock_after_zero", locked, (i == 24));
    end

    // Saturation on the long-tolerance copy.
    chk("sat_locked_start", s_locked, 1);
    drive(1'b0, 1'b0, 1'b1);
    chk("sat_cleared", s_err_count, 0);
    for (int k = 1; k <= 65540; k++) begin
      send(1'b1, 1'b0);
      if (k == 65534) chk("sat_below", s_err_count, 32'hFFFE);
      if (k == 65535) chk("sat_reach", s_err_count, 32'hFFFF);
    end
    chk("sat_hold", s_err_count, 32'hFFFF);
    chk("sat_pulse", s_err_pulse, 1);
    chk("sat_locked", s_locked, 1);
    chk("sat_lost", s_lost, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
